// File: rtl/uop_pair_queue.sv
// Decoupling FIFO between uop fetch and decode: one instruction pair (with branch
// tags) in and one out per cycle, flushable by a synchronous clear.
module uop_pair_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TAG_BITS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     prev_valid,
  input  logic [31:0]              in_instruction_1,
  input  logic [31:0]              in_instruction_2,
  input  logic [TAG_BITS-1:0]      in_branch_tag_1,
  input  logic [TAG_BITS-1:0]      in_branch_tag_2,
  output logic                     stalled,
  input  logic                     next_stalled,
  output logic                     valid,
  output logic [31:0]              instruction_1,
  output logic [31:0]              instruction_2,
  output logic [TAG_BITS-1:0]      branch_tag_1,
  output logic [TAG_BITS-1:0]      branch_tag_2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]         instr_1;
    logic [31:0]         instr_2;
    logic [TAG_BITS-1:0] tag_1;
    logic [TAG_BITS-1:0] tag_2;
  } pair_t;

  pair_t             mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;
  pair_t             in_pair, head_pair;

  assign valid   = (count_q != '0);
  assign stalled = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;

  // Full blocks push even when popping; empty blocks pop even when pushing.
  assign push = prev_valid & ~stalled;
  assign pop  = valid & ~next_stalled;

  assign in_pair = '{instr_1: in_instruction_1, instr_2: in_instruction_2,
                     tag_1: in_branch_tag_1, tag_2: in_branch_tag_2};

  // Storage is not reset; the head is masked to zero while empty.
  assign head_pair     = valid ? mem_q[rd_ptr_q] : '0;
  assign instruction_1 = head_pair.instr_1;
  assign instruction_2 = head_pair.instr_2;
  assign branch_tag_1  = head_pair.tag_1;
  assign branch_tag_2  = head_pair.tag_2;

  // Pointer and occupancy next-state; clear overrides push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= in_pair;
  end

endmodule
